// File: rtl/lives_hud_pkg.sv
// Shared types and constants for the lives HUD controller.
//   hud_state_e : controller FSM state encoding (3-bit)
//   HEART_FULL  : colour of a remaining life
//   HEART_EMPTY : colour of a lost life
//   MAX_LIVES_DEF : default number of heart slots
package lives_hud_pkg;

  localparam int unsigned MAX_LIVES_DEF = 5;

  localparam logic [11:0] HEART_FULL  = 12'hF00;
  localparam logic [11:0] HEART_EMPTY = 12'h444;

  typedef enum logic [2:0] {
    StPlay      = 3'd0,
    StBlink     = 3'd1,
    StDeadBlink = 3'd2,
    StOverRel   = 3'd3,
    StOver      = 3'd4,
    StRestart   = 3'd5
  } hud_state_e;

endpackage

// File: rtl/lives_hud_ctrl_blink_timer.sv
// Blink timer for the bomberman hit sequence. One instance is shared by the
// normal and final-life blink states.
//   clk, reset : clock, asynchronous active-high reset
//   start      : clear both counters and begin counting
//   clear      : clear both counters and stop
//   phase      : toggle_cnt[0]; 0 during the first half-period
//   done       : high in the last cycle of the last half-period
module blink_timer #(
  parameter int unsigned BLINK_HALF    = 12_500_000,
  parameter int unsigned BLINK_TOGGLES = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic phase,
  output logic done
);

  localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned TglW = $clog2(BLINK_TOGGLES) + 1;

  logic [CntW-1:0] blink_cnt_q;
  logic [TglW-1:0] toggle_cnt_q;
  logic            active_q;
  logic            wrap;

  assign wrap  = (blink_cnt_q == CntW'(BLINK_HALF - 1));
  assign done  = active_q && wrap && (toggle_cnt_q == TglW'(BLINK_TOGGLES - 1));
  assign phase = toggle_cnt_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      active_q     <= 1'b0;
    end else if (start) begin
      blink_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      active_q     <= 1'b1;
    end else if (clear) begin
      blink_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      active_q     <= 1'b0;
    end else if (active_q) begin
      if (wrap) begin
        blink_cnt_q  <= '0;
        toggle_cnt_q <= toggle_cnt_q + TglW'(1);
      end else begin
        blink_cnt_q <= blink_cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/lives_hud_ctrl.sv
// Lives HUD controller: consumer of the lives tracker's lives/gameover outputs.
// Detects life losses, blinks the bomberman sprite during invisibility, draws
// the heart row, and runs the game-over / restart handshake.
//   clk, reset  : clock, asynchronous active-high reset
//   x, y        : current pixel position
//   lives       : lives count from the tracker (values above MAX_LIVES clamp)
//   gameover    : tracker game-over flag
//   start_btn   : debounced start button level
//   bm_visible  : bomberman sprite gate
//   hit_pulse   : one-cycle pulse per life loss
//   hud_on      : pixel is inside a heart slot (1-cycle latency)
//   hud_rgb     : heart colour for the pixel, 0 outside slots
//   banner_on   : pixel is inside the flashing game-over banner
//   restart     : one-cycle game-state reset request
// Build option: define LIVES_HUD_BANNER_EN to build the game-over banner;
// otherwise banner_on is tied low.
module lives_hud_ctrl
  import lives_hud_pkg::*;
#(
  parameter int unsigned MAX_LIVES     = MAX_LIVES_DEF,
  parameter int unsigned BLINK_HALF    = 12_500_000,
  parameter int unsigned BLINK_TOGGLES = 12,
  parameter int unsigned HUD_X0        = 16,
  parameter int unsigned HUD_Y0        = 8,
  parameter int unsigned HEART_W       = 16,
  parameter int unsigned HEART_GAP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [2:0]  lives,
  input  logic        gameover,
  input  logic        start_btn,
  output logic        bm_visible,
  output logic        hit_pulse,
  output logic        hud_on,
  output logic [11:0] hud_rgb,
  output logic        banner_on,
  output logic        restart
);

  localparam int unsigned SlotPitch = HEART_W + HEART_GAP;

  hud_state_e  state_q, state_d;
  logic [2:0]  lives_c, lives_prev_q;
  logic        loss, hit_q;
  logic        tmr_start, tmr_clear, tmr_phase, tmr_done;
  logic        blinking;
  logic        hud_on_d, hud_on_q;
  logic [11:0] hud_rgb_d, hud_rgb_q;
  logic        y_in_row;

  assign lives_c  = (lives > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives;
  assign loss     = (lives_c < lives_prev_q);
  assign blinking = (state_q == StBlink) || (state_q == StDeadBlink);

  blink_timer #(
    .BLINK_HALF    (BLINK_HALF),
    .BLINK_TOGGLES (BLINK_TOGGLES)
  ) u_blink_timer (
    .clk   (clk),
    .reset (reset),
    .start (tmr_start),
    .clear (tmr_clear),
    .phase (tmr_phase),
    .done  (tmr_done)
  );

  // The shadow is reloaded in RESTART so the tracker's reload is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lives_prev_q <= 3'(MAX_LIVES);
      hit_q        <= 1'b0;
      state_q      <= StPlay;
    end else begin
      lives_prev_q <= (state_q == StRestart) ? 3'(MAX_LIVES) : lives_c;
      hit_q        <= loss;
      state_q      <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    unique case (state_q)
      StPlay: begin
        if (loss) begin
          tmr_start = 1'b1;
          state_d   = gameover ? StDeadBlink : StBlink;
        end else if (gameover) begin
          state_d = StOverRel;
        end
      end
      StBlink: begin
        // A further loss restarts the whole invisibility window.
        if (loss) begin
          tmr_start = 1'b1;
          state_d   = gameover ? StDeadBlink : StBlink;
        end else if (tmr_done) begin
          tmr_clear = 1'b1;
          state_d   = StPlay;
        end
      end
      StDeadBlink: begin
        if (tmr_done) begin
          tmr_clear = 1'b1;
          state_d   = StOverRel;
        end
      end
      StOverRel: begin
        // A button still held from play must be released first.
        if (!start_btn) state_d = StOver;
      end
      StOver: begin
        if (start_btn) state_d = StRestart;
      end
      StRestart: state_d = StPlay;
      default:   state_d = StPlay;
    endcase
  end

  // The first half-period of a blink is hidden (phase starts at 0).
  assign bm_visible = (state_q == StPlay) || (blinking && tmr_phase);
  assign restart    = (state_q == StRestart);
  assign hit_pulse  = hit_q;

  // Slot bounds use one extra bit so an end bound never wraps past 1023.
  assign y_in_row = ({1'b0, y} >= 11'(HUD_Y0)) && ({1'b0, y} < 11'(HUD_Y0 + HEART_W));

  always_comb begin
    hud_on_d  = 1'b0;
    hud_rgb_d = 12'h000;
    for (int unsigned i = 0; i < MAX_LIVES; i++) begin
      if (y_in_row && ({1'b0, x} >= 11'(HUD_X0 + i * SlotPitch)) &&
          ({1'b0, x} < 11'(HUD_X0 + i * SlotPitch + HEART_W))) begin
        hud_on_d = 1'b1;
        if (i < 32'(lives_c)) begin
          hud_rgb_d = HEART_FULL;
        end else if (blinking && (i == 32'(lives_c))) begin
          hud_rgb_d = bm_visible ? HEART_FULL : HEART_EMPTY;
        end else begin
          hud_rgb_d = HEART_EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hud_on_q  <= 1'b0;
      hud_rgb_q <= 12'h000;
    end else begin
      hud_on_q  <= hud_on_d;
      hud_rgb_q <= hud_rgb_d;
    end
  end

  assign hud_on  = hud_on_q;
  assign hud_rgb = hud_rgb_q;

`ifdef LIVES_HUD_BANNER_EN
  logic [24:0] flash_q;
  logic        banner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_q  <= '0;
      banner_q <= 1'b0;
    end else begin
      flash_q  <= flash_q + 25'd1;
      banner_q <= ((state_q == StOverRel) || (state_q == StOver)) && flash_q[24] &&
                  (x >= 10'd192) && (x < 10'd448) && (y >= 10'd208) && (y < 10'd272);
    end
  end

  assign banner_on = banner_q;
`else
  assign banner_on = 1'b0;
`endif

endmodule

// File: tb/tb_lives_hud_ctrl.sv
// Self-checking bench for lives_hud_ctrl with a short blink (4 x 4 cycles).
module tb_lives_hud_ctrl;
  import lives_hud_pkg::*;

  localparam int TbHalf    = 4;
  localparam int TbToggles = 4;
  localparam int TbBlink   = TbHalf * TbToggles;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic [2:0]  lives;
  logic        gameover, start_btn;
  logic        bm_visible, hit_pulse, hud_on, banner_on, restart;
  logic [11:0] hud_rgb;

  lives_hud_ctrl #(
    .MAX_LIVES     (5),
    .BLINK_HALF    (TbHalf),
    .BLINK_TOGGLES (TbToggles),
    .HUD_X0        (16),
    .HUD_Y0        (8),
    .HEART_W       (16),
    .HEART_GAP     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .lives      (lives),
    .gameover   (gameover),
    .start_btn  (start_btn),
    .bm_visible (bm_visible),
    .hit_pulse  (hit_pulse),
    .hud_on     (hud_on),
    .hud_rgb    (hud_rgb),
    .banner_on  (banner_on),
    .restart    (restart)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  lives;
    logic        on;
    logic [11:0] rgb;
  } pix_vec_t;

  typedef struct {
    logic        on;
    logic [11:0] rgb;
    int          idx;
  } exp_t;

  exp_t     sb_q[$];
  exp_t     mon_e;
  pix_vec_t vecs[17];
  int       checks = 0;
  int       errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: HUD outputs appear one cycle after the pixel is driven.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check($sformatf("hud_on[%0d]", mon_e.idx), 32'(hud_on), 32'(mon_e.on));
        check($sformatf("hud_rgb[%0d]", mon_e.idx), 32'(hud_rgb), 32'(mon_e.rgb));
      end
    end
  end

  task automatic drive_pix(input pix_vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    x     = v.x;
    y     = v.y;
    lives = v.lives;
    e.on  = v.on;
    e.rgb = v.rgb;
    e.idx = idx;
    sb_q.push_back(e);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  // Called at the sample just after the losing edge (k = 0).
  task automatic run_blink(input string tag, input hud_state_e st, input bit flash);
    logic exp_bm, prev_bm;
    prev_bm = 1'b0;
    for (int k = 0; k < TbBlink; k++) begin
      exp_bm = ((k / TbHalf) % 2) != 0;
      check($sformatf("%s_bm[%0d]", tag, k), 32'(bm_visible), 32'(exp_bm));
      check($sformatf("%s_hit[%0d]", tag, k), 32'(hit_pulse), (k == 0) ? 32'd1 : 32'd0);
      check($sformatf("%s_st[%0d]", tag, k), 32'(dut.state_q), 32'(st));
      if (flash) begin
        check($sformatf("%s_flash[%0d]", tag, k), 32'(hud_rgb),
              32'((k >= 1 && prev_bm) ? 12'hF00 : 12'h444));
      end
      prev_bm = exp_bm;
      step();
    end
  endtask

  initial begin
    vecs[0]  = '{10'd16,   10'd8,  3'd5, 1'b1, 12'hF00};
    vecs[1]  = '{10'd31,   10'd23, 3'd5, 1'b1, 12'hF00};
    vecs[2]  = '{10'd32,   10'd8,  3'd5, 1'b0, 12'h000};
    vecs[3]  = '{10'd35,   10'd8,  3'd5, 1'b0, 12'h000};
    vecs[4]  = '{10'd36,   10'd8,  3'd5, 1'b1, 12'hF00};
    vecs[5]  = '{10'd111,  10'd8,  3'd5, 1'b1, 12'hF00};
    vecs[6]  = '{10'd112,  10'd8,  3'd5, 1'b0, 12'h000};
    vecs[7]  = '{10'd15,   10'd8,  3'd5, 1'b0, 12'h000};
    vecs[8]  = '{10'd16,   10'd7,  3'd5, 1'b0, 12'h000};
    vecs[9]  = '{10'd16,   10'd24, 3'd5, 1'b0, 12'h000};
    vecs[10] = '{10'd1023, 10'd8,  3'd5, 1'b0, 12'h000};
    vecs[11] = '{10'd96,   10'd8,  3'd7, 1'b1, 12'hF00};
    vecs[12] = '{10'd60,   10'd20, 3'd7, 1'b1, 12'hF00};
    vecs[13] = '{10'd0,    10'd0,  3'd5, 1'b0, 12'h000};
    // After the first loss (lives = 4).
    vecs[14] = '{10'd96,   10'd8,  3'd4, 1'b1, 12'h444};
    vecs[15] = '{10'd76,   10'd8,  3'd4, 1'b1, 12'hF00};
    vecs[16] = '{10'd111,  10'd23, 3'd4, 1'b1, 12'h444};

    reset = 1'b1; x = '0; y = '0; lives = 3'd5; gameover = 1'b0; start_btn = 1'b0;
    #2;
    check("rst_state", 32'(dut.state_q), 32'(StPlay));
    check("rst_bm", 32'(bm_visible), 32'd1);
    check("rst_hit", 32'(hit_pulse), 32'd0);
    check("rst_hud_on", 32'(hud_on), 32'd0);
    check("rst_hud_rgb", 32'(hud_rgb), 32'd0);
    check("rst_restart", 32'(restart), 32'd0);
    check("rst_banner", 32'(banner_on), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step(); step();
    check("play_bm", 32'(bm_visible), 32'd1);
    check("play_hit", 32'(hit_pulse), 32'd0);
    check("play_state", 32'(dut.state_q), 32'(StPlay));

    for (int i = 0; i < 14; i++) drive_pix(vecs[i], i);
    wait_sb();

    // Game over without a loss goes straight to the release wait.
    step();
    gameover = 1'b1;
    step();
    check("go_direct_state", 32'(dut.state_q), 32'(StOverRel));
    check("go_direct_hit", 32'(hit_pulse), 32'd0);
    check("go_direct_bm", 32'(bm_visible), 32'd0);
    reset = 1'b1;
    #1;
    check("async_rst_state", 32'(dut.state_q), 32'(StPlay));
    gameover = 1'b0;
    step();
    reset = 1'b0;
    step();

    // First loss 5 -> 4 with the slot-4 heart watched for flashing.
    x = 10'd96; y = 10'd8; lives = 3'd5;
    step();
    lives = 3'd4;
    step();
    run_blink("blink1", StBlink, 1'b1);
    check("blink1_end_state", 32'(dut.state_q), 32'(StPlay));
    check("blink1_end_bm", 32'(bm_visible), 32'd1);
    for (int i = 14; i < 17; i++) drive_pix(vecs[i], i);
    wait_sb();

    // Second loss in the middle of a blink restarts the window.
    step();
    lives = 3'd3;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mid_bm[%0d]", k), 32'(bm_visible), 32'((k / TbHalf) % 2));
      step();
    end
    check("mid_bm[5]", 32'(bm_visible), 32'd1);
    lives = 3'd2;
    step();
    run_blink("blink2", StBlink, 1'b0);
    check("blink2_end_state", 32'(dut.state_q), 32'(StPlay));

    // Last life, with start held through the blink.
    lives = 3'd1;
    step();
    run_blink("blink3", StBlink, 1'b0);
    start_btn = 1'b1; lives = 3'd0; gameover = 1'b1;
    step();
    run_blink("dead", StDeadBlink, 1'b0);
    check("dead_end_state", 32'(dut.state_q), 32'(StOverRel));
    check("dead_end_bm", 32'(bm_visible), 32'd0);
    x = 10'd300; y = 10'd240;
    repeat (5) step();
    check("held_state", 32'(dut.state_q), 32'(StOverRel));
    check("held_banner", 32'(banner_on), 32'd0);
    start_btn = 1'b0;
    step();
    check("over_state", 32'(dut.state_q), 32'(StOver));
    check("over_restart", 32'(restart), 32'd0);
    check("over_banner", 32'(banner_on), 32'd0);
    start_btn = 1'b1;
    step();
    check("restart_pulse", 32'(restart), 32'd1);
    check("restart_state", 32'(dut.state_q), 32'(StRestart));
    lives = 3'd5; gameover = 1'b0; start_btn = 1'b0;
    step();
    check("after_restart", 32'(restart), 32'd0);
    check("after_state", 32'(dut.state_q), 32'(StPlay));
    check("after_hit0", 32'(hit_pulse), 32'd0);
    step();
    check("after_hit1", 32'(hit_pulse), 32'd0);
    check("after_bm", 32'(bm_visible), 32'd1);

    // Reset in the middle of the final blink.
    lives = 3'd0; gameover = 1'b1;
    step();
    check("rdb_state", 32'(dut.state_q), 32'(StDeadBlink));
    step(); step();
    #2 reset = 1'b1;
    #1;
    check("rdb_rst_state", 32'(dut.state_q), 32'(StPlay));
    check("rdb_rst_bm", 32'(bm_visible), 32'd1);
    lives = 3'd5; gameover = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("rdb_rel_state", 32'(dut.state_q), 32'(StPlay));
    check("rdb_rel_bm", 32'(bm_visible), 32'd1);
    check("rdb_rel_restart", 32'(restart), 32'd0);
    check("rdb_rel_hit", 32'(hit_pulse), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
